// File: rtl/lizard_collider.sv
// Leading-edge tile/bounds collision probe for the lizard sprite's next horizontal move.
// One tile lookup per request; the result is registered three cycles after start is accepted.
module lizard_collider #(
    parameter int TILE_COLS = 20,
    parameter int SCREEN_W  = 640,
    parameter int SPRITE_W  = 32
) (
    input  logic        sim_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] lizardState,
    output logic [8:0]  tileAddr,
    output logic        tileRd,
    input  logic        tileData,
    output logic [1:0]  lizardCol,
    output logic        colValid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    localparam logic [10:0] SPR_M1   = 11'(SPRITE_W - 1);
    localparam logic [10:0] SPR_HALF = 11'(SPRITE_W / 2);
    localparam logic [10:0] SCR_M1   = 11'(SCREEN_W - 1);
    localparam logic [10:0] COLS_W   = 11'(TILE_COLS);

    state_t      state_q, state_d;
    logic [9:0]  xpos_q, xpos_d;
    logic [9:0]  ypos_q, ypos_d;
    logic [4:0]  xspd_q, xspd_d;
    logic        xdir_q, xdir_d;
    logic        rd_q, rd_d;
    logic        bhit_q, bhit_d;
    logic [8:0]  tileAddr_q, tileAddr_d;
    logic        tileRd_q, tileRd_d;
    logic [1:0]  lizardCol_q, lizardCol_d;
    logic        colValid_q, colValid_d;

    logic [10:0] nx, redge, px, py, row, addr_full;
    logic        lhit, rhit, bhit, hit;
    logic        unused_bits;

    // Probe datapath, evaluated from the latched state word
    always_comb begin
        nx = xdir_q ? ({1'b0, xpos_q} + {6'b0, xspd_q})
                    : ({1'b0, xpos_q} - {6'b0, xspd_q});
        redge = nx + SPR_M1;
        lhit  = ~xdir_q & (xpos_q < {5'b0, xspd_q});
        rhit  = xdir_q & (redge > SCR_M1);
        bhit  = lhit | rhit;
        px    = xdir_q ? redge : nx;
        py    = {1'b0, ypos_q} + SPR_HALF;
        row   = (py > 11'd479) ? 11'd14 : (py >> 5);
        addr_full = row * COLS_W + (px >> 5);
        hit   = rd_q ? tileData : bhit_q;
    end

    assign unused_bits = ^{lizardState[6:2], lizardState[0], addr_full[10:9]};

    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        xspd_d      = xspd_q;
        xdir_d      = xdir_q;
        rd_d        = rd_q;
        bhit_d      = bhit_q;
        tileAddr_d  = tileAddr_q;
        tileRd_d    = 1'b0;
        lizardCol_d = lizardCol_q;
        colValid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xpos_d  = lizardState[31:22];
                    ypos_d  = lizardState[21:12];
                    xspd_d  = lizardState[11:7];
                    xdir_d  = lizardState[1];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // An out-of-bounds move needs no tile lookup; the address bus is left untouched
                tileRd_d = ~bhit;
                rd_d     = ~bhit;
                bhit_d   = bhit;
                if (!bhit) begin
                    tileAddr_d = addr_full[8:0];
                end
                state_d = WAIT;
            end
            WAIT: begin
                state_d = DONE;
            end
            DONE: begin
                lizardCol_d = {hit & xdir_q, hit & ~xdir_q};
                colValid_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            xpos_q      <= '0;
            ypos_q      <= '0;
            xspd_q      <= '0;
            xdir_q      <= 1'b0;
            rd_q        <= 1'b0;
            bhit_q      <= 1'b0;
            tileAddr_q  <= '0;
            tileRd_q    <= 1'b0;
            lizardCol_q <= 2'b00;
            colValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            xspd_q      <= xspd_d;
            xdir_q      <= xdir_d;
            rd_q        <= rd_d;
            bhit_q      <= bhit_d;
            tileAddr_q  <= tileAddr_d;
            tileRd_q    <= tileRd_d;
            lizardCol_q <= lizardCol_d;
            colValid_q  <= colValid_d;
        end
    end

    assign tileAddr  = tileAddr_q;
    assign tileRd    = tileRd_q;
    assign lizardCol = lizardCol_q;
    assign colValid  = colValid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lizard_collider.sv
// Directed bench for lizard_collider: stimulus pushes expected results into a queue,
// an independent monitor pops and compares on every colValid pulse.
module tb_lizard_collider;

    logic        sim_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] lizardState;
    logic [8:0]  tileAddr;
    logic        tileRd;
    logic        tileData;
    logic [1:0]  lizardCol;
    logic        colValid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    logic [1:0] exp_q[$];

    lizard_collider #(.TILE_COLS(20), .SCREEN_W(640), .SPRITE_W(32)) dut (
        .sim_clk(sim_clk), .reset(reset), .start(start), .lizardState(lizardState),
        .tileAddr(tileAddr), .tileRd(tileRd), .tileData(tileData),
        .lizardCol(lizardCol), .colValid(colValid), .busy(busy)
    );

    always #5 sim_clk = ~sim_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y, input int s, input int d);
        logic [9:0] xv = 10'(x);
        logic [9:0] yv = 10'(y);
        logic [4:0] sv = 5'(s);
        logic       dv = 1'(d);
        return {xv, yv, sv, 5'b0, dv, 1'b0};
    endfunction

    // Scoreboard monitor: every colValid pulse must match the oldest pending expectation
    initial begin
        forever begin
            @(negedge sim_clk);
            if (colValid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_colValid: got lizardCol=%0d, expected no pulse at %0t", lizardCol, $time);
                end else begin
                    chk("sb_lizardCol", int'(lizardCol), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // One request; edges counted from N, the edge at which start is sampled
    task automatic issue(input logic [31:0] st, input logic td, input logic [1:0] ec,
                         input logic erd, input int ea, input bit dup, input string tag);
        int p0;
        @(negedge sim_clk);
        lizardState = st;
        tileData    = td;
        start       = 1'b1;
        exp_q.push_back(ec);
        p0 = pulses;
        @(posedge sim_clk); #1;
        start       = dup;
        lizardState = ~st;
        chk({tag, "_busy_N"}, int'(busy), 1);
        @(posedge sim_clk); #1;
        start = dup;
        chk({tag, "_tileRd_N1"}, int'(tileRd), int'(erd));
        chk({tag, "_tileAddr_N1"}, int'(tileAddr), ea);
        @(posedge sim_clk); #1;
        start = 1'b0;
        chk({tag, "_tileRd_N2"}, int'(tileRd), 0);
        chk({tag, "_colValid_N2"}, int'(colValid), 0);
        @(posedge sim_clk); #1;
        chk({tag, "_colValid_N3"}, int'(colValid), 1);
        chk({tag, "_lizardCol_N3"}, int'(lizardCol), int'(ec));
        @(posedge sim_clk); #1;
        chk({tag, "_colValid_N4"}, int'(colValid), 0);
        chk({tag, "_busy_N4"}, int'(busy), 0);
        chk({tag, "_lizardCol_hold"}, int'(lizardCol), int'(ec));
        chk({tag, "_pulse_count"}, pulses - p0, 1);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        lizardState = '0;
        tileData    = 1'b0;
        #1;
        chk("rst_lizardCol", int'(lizardCol), 0);
        chk("rst_colValid", int'(colValid), 0);
        chk("rst_tileRd", int'(tileRd), 0);
        chk("rst_tileAddr", int'(tileAddr), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(negedge sim_clk);
        reset = 1'b0;

        issue(pack(200, 150, 3, 1), 1'b1, 2'b10, 1'b1, 107, 1'b0, "right_tile");
        issue(pack(100, 150, 4, 0), 1'b0, 2'b00, 1'b1, 103, 1'b0, "left_free");
        issue(pack(2,   150, 3, 0), 1'b1, 2'b01, 1'b0, 103, 1'b0, "left_bound");
        issue(pack(606, 150, 3, 1), 1'b0, 2'b10, 1'b0, 103, 1'b0, "right_bound");
        issue(pack(64,  470, 0, 0), 1'b0, 2'b00, 1'b1, 282, 1'b0, "row_clamp");
        issue(pack(0,   0,   0, 0), 1'b1, 2'b01, 1'b1, 0,   1'b0, "zero_speed");
        issue(pack(300, 100, 5, 0), 1'b1, 2'b01, 1'b1, 69,  1'b1, "dup_start");

        // Abort an evaluation with reset two edges after start
        @(negedge sim_clk);
        lizardState = pack(100, 150, 4, 0);
        tileData    = 1'b1;
        start       = 1'b1;
        @(posedge sim_clk); #1;
        start = 1'b0;
        @(posedge sim_clk);
        @(posedge sim_clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_lizardCol", int'(lizardCol), 0);
        chk("abort_colValid", int'(colValid), 0);
        chk("abort_tileRd", int'(tileRd), 0);
        chk("abort_tileAddr", int'(tileAddr), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (3) @(negedge sim_clk);
        reset = 1'b0;
        issue(pack(200, 150, 3, 1), 1'b1, 2'b10, 1'b1, 107, 1'b0, "after_reset");

        repeat (3) @(negedge sim_clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
